ysyx_2022040010_rw_sched: RTL and testbench
===========================================

YSYX_2022040010_RW_SCHED -- requirements
Module: ysyx_2022040010_rw_sched

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 4, write-buffer entry count (power of 2, >=2).
REQ-002 SHALL have port clock  in  1  sole clock; all state rises on posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports rd_req_i in 1, rd_addr_i in 64, rd_size_i in 2: read request; held stable until granted.
REQ-005 SHALL have ports rd_gnt_o out 1 (read launched), rd_done_o out 1 (read complete pulse), rd_data_o out 64 (read data).
REQ-006 SHALL have ports wr_req_i in 1, wr_addr_i in 64, wr_data_i in 64, wr_mask_i in 8, wr_size_i in 2: posted write request.
REQ-007 SHALL have port wr_gnt_o out 1, write accepted into buffer this cycle when high with wr_req_i.
REQ-008 SHALL have ports fence_i in 1 (drain request, level) and fence_done_o out 1 (drain complete pulse).
REQ-009 SHALL have ports rw_valid_o out 1, rw_ready_i in 1, rw_req_o out 1 (0 read, 1 write), rw_addr_o out 64, rw_size_o out 2, data_write_o out 64, w_mask_o out 8, rw_id_o out 4, data_read_i in 64 toward axi_rw.

Function
REQ-010 SHALL buffer writes in a WBUF_DEPTH-entry FIFO {addr, data, mask, size}, issued to rw port in acceptance order.
REQ-011 SHALL drive wr_gnt_o = ~full combinationally; no same-cycle bypass when full, even if an entry pops that cycle.
REQ-012 SHALL implement FSM IDLE, RD, WR; RD/WR hold rw_valid_o=1 with registered command until rw_ready_i=1, then return to IDLE next cycle.
REQ-013 SHALL evaluate in IDLE with priority: (a) buffer non-empty and (full, fence_i, or RAW hazard) -> WR; (b) rd_req_i -> RD; (c) buffer non-empty -> WR; else stay.
REQ-014 SHALL define RAW hazard as rd_req_i with rd_addr_i[63:3] equal to addr[63:3] of any valid buffered entry; a write accepted in the same cycle is younger than the read and excluded.
REQ-015 SHALL pulse rd_gnt_o one cycle on IDLE->RD, latching rd_addr_i/rd_size_i.
REQ-016 SHALL pop the FIFO head on IDLE->WR, latching it into command registers; entry count decrements that cycle.
REQ-017 SHALL drive rw_id_o = 4'd0 for reads, 4'd1 for writes; rw_req_o per state.
REQ-018 SHALL, on RD with rw_ready_i, register data_read_i into rd_data_o and pulse rd_done_o next cycle; rd_data_o holds until next read completes.
REQ-019 SHALL keep a read and a write never concurrently outstanding; at most one rw transaction in flight.
REQ-020 SHALL pulse fence_done_o one cycle when fence_i=1, FSM IDLE, buffer empty, and not already pulsed for this fence_i assertion; re-arm when fence_i falls.
REQ-021 SHALL accept writes during fence drain; fence completes only when the buffer is empty.
REQ-022 SHALL not grant reads while fence_i=1 and buffer non-empty.
REQ-023 SHALL handle simultaneous push and pop when not full: count unchanged, FIFO pointers both advance, wrap at WBUF_DEPTH.

Reset
REQ-024 SHALL on reset force IDLE, empty FIFO (pointers/count 0), fence armed, all outputs 0 (rw_valid_o, rd_gnt_o, rd_done_o, fence_done_o, rd_data_o, command registers), wr_gnt_o=1 once reset releases.
REQ-025 SHALL abandon any in-flight transaction on reset mid-operation; no rd_done_o after release.

Verification
REQ-026 SHALL pass: idle, rd_req_i addr 0x8000_0010, rw_ready_i after 3 cycles -> rd_gnt_o pulse, rw_valid_o 3 cycles, rw_req_o=0, rd_done_o with data_read_i value.
REQ-027 SHALL pass: 5 back-to-back writes, no reads, rw_ready_i low -> wr_gnt_o low after buffer fills at 4 (one popped into WR), rw order = acceptance order.
REQ-028 SHALL pass: write 0x8000_0008 buffered, then read 0x8000_000C -> write issued first, read granted only after write rw_ready_i.
REQ-029 SHALL pass: read 0x8000_0100 with non-hazard write pending, buffer not full -> read issued before write.
REQ-030 SHALL pass: 3 writes buffered, fence_i high -> 3 write transactions, then one fence_done_o pulse; no second pulse while fence_i held.
REQ-031 SHALL pass: reset asserted mid-WR with 2 entries buffered -> rw_valid_o 0 immediately, buffer empty, wr_gnt_o 1 after release.

Source files
------------

// File: rtl/ysyx_2022040010_rw_sched.sv
// Read/write scheduler in front of axi_rw: posted writes go through a small FIFO,
// reads are served with priority unless they hit a buffered write or a drain is pending.
module ysyx_2022040010_rw_sched #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  // read requester
  input  logic        rd_req_i,
  input  logic [63:0] rd_addr_i,
  input  logic [1:0]  rd_size_i,
  output logic        rd_gnt_o,
  output logic        rd_done_o,
  output logic [63:0] rd_data_o,
  // posted write requester
  input  logic        wr_req_i,
  input  logic [63:0] wr_addr_i,
  input  logic [63:0] wr_data_i,
  input  logic [7:0]  wr_mask_i,
  input  logic [1:0]  wr_size_i,
  output logic        wr_gnt_o,
  // drain
  input  logic        fence_i,
  output logic        fence_done_o,
  // toward axi_rw
  output logic        rw_valid_o,
  input  logic        rw_ready_i,
  output logic        rw_req_o,
  output logic [63:0] rw_addr_o,
  output logic [1:0]  rw_size_o,
  output logic [63:0] data_write_o,
  output logic [7:0]  w_mask_o,
  output logic [3:0]  rw_id_o,
  input  logic [63:0] data_read_i,
  // debug view of the FSM (0 idle, 1 read, 2 write)
  output logic [1:0]  fsm_state
);

  localparam int PW = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

  state_t state, state_n;

  logic [63:0] buf_addr [WBUF_DEPTH];
  logic [63:0] buf_data [WBUF_DEPTH];
  logic [7:0]  buf_mask [WBUF_DEPTH];
  logic [1:0]  buf_size [WBUF_DEPTH];

  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop, hazard;

  logic        cmd_req;
  logic [63:0] cmd_addr, cmd_data;
  logic [7:0]  cmd_mask;
  logic [1:0]  cmd_size;

  logic rd_done_q, fence_done_q, fence_armed, fence_fire;

  assign full     = (count == (PW+1)'(WBUF_DEPTH));
  assign empty    = (count == '0);
  assign wr_gnt_o = ~full;
  assign push     = wr_req_i & ~full;

  // Only entries already in the buffer count; a write accepted this cycle is younger.
  always_comb begin
    logic [PW-1:0] off;
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      off = PW'(i) - rptr;
      if (({1'b0, off} < count) && (buf_addr[i][63:3] == rd_addr_i[63:3]))
        hazard = 1'b1;
    end
    hazard = hazard & rd_req_i;
  end

  always_comb begin
    state_n  = state;
    rd_gnt_o = 1'b0;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && (full || fence_i || hazard)) begin
          state_n = S_WR;
          pop     = 1'b1;
        end else if (rd_req_i) begin
          state_n  = S_RD;
          rd_gnt_o = 1'b1;
        end else if (!empty) begin
          state_n = S_WR;
          pop     = 1'b1;
        end
      end
      S_RD, S_WR: if (rw_ready_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign fence_fire = fence_i & fence_armed & (state == S_IDLE) & empty;

  always_ff @(posedge clock) begin
    if (push) begin
      buf_addr[wptr] <= wr_addr_i;
      buf_data[wptr] <= wr_data_i;
      buf_mask[wptr] <= wr_mask_i;
      buf_size[wptr] <= wr_size_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      cmd_req      <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      cmd_mask     <= '0;
      cmd_size     <= '0;
      rd_data_o    <= '0;
      rd_done_q    <= 1'b0;
      fence_done_q <= 1'b0;
      fence_armed  <= 1'b1;
    end else begin
      state <= state_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        cmd_req  <= 1'b1;
        cmd_addr <= buf_addr[rptr];
        cmd_data <= buf_data[rptr];
        cmd_mask <= buf_mask[rptr];
        cmd_size <= buf_size[rptr];
      end else if (rd_gnt_o) begin
        cmd_req  <= 1'b0;
        cmd_addr <= rd_addr_i;
        cmd_data <= '0;
        cmd_mask <= '0;
        cmd_size <= rd_size_i;
      end
      rd_done_q <= (state == S_RD) && rw_ready_i;
      if ((state == S_RD) && rw_ready_i) rd_data_o <= data_read_i;
      fence_done_q <= fence_fire;
      if (!fence_i)        fence_armed <= 1'b1;
      else if (fence_fire) fence_armed <= 1'b0;
    end
  end

  // rw handshake: command is held stable while rw_valid_o=1; it transfers on the
  // posedge where rw_valid_o & rw_ready_i, and the FSM is back in IDLE afterwards.
  assign rw_valid_o   = (state != S_IDLE);
  assign rw_req_o     = cmd_req;
  assign rw_addr_o    = cmd_addr;
  assign rw_size_o    = cmd_size;
  assign data_write_o = cmd_data;
  assign w_mask_o     = cmd_mask;
  assign rw_id_o      = {3'b000, cmd_req};
  assign rd_done_o    = rd_done_q;
  assign fence_done_o = fence_done_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_ysyx_2022040010_rw_sched.sv
// Directed bench for ysyx_2022040010_rw_sched: reads, write buffering, RAW ordering,
// fence drain and mid-transaction reset.
module tb_ysyx_2022040010_rw_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req_i = 1'b0;
  logic [63:0] rd_addr_i = '0;
  logic [1:0]  rd_size_i = '0;
  logic        rd_gnt_o, rd_done_o;
  logic [63:0] rd_data_o;
  logic        wr_req_i = 1'b0;
  logic [63:0] wr_addr_i = '0;
  logic [63:0] wr_data_i = '0;
  logic [7:0]  wr_mask_i = '0;
  logic [1:0]  wr_size_i = '0;
  logic        wr_gnt_o;
  logic        fence_i = 1'b0;
  logic        fence_done_o;
  logic        rw_valid_o;
  logic        rw_ready_i = 1'b0;
  logic        rw_req_o;
  logic [63:0] rw_addr_o, data_write_o;
  logic [1:0]  rw_size_o;
  logic [7:0]  w_mask_o;
  logic [3:0]  rw_id_o;
  logic [63:0] data_read_i = '0;
  logic [1:0]  fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_data_q[$];

  ysyx_2022040010_rw_sched #(.WBUF_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_size_i(rd_size_i),
    .rd_gnt_o(rd_gnt_o), .rd_done_o(rd_done_o), .rd_data_o(rd_data_o),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_mask_i(wr_mask_i), .wr_size_i(wr_size_i), .wr_gnt_o(wr_gnt_o),
    .fence_i(fence_i), .fence_done_o(fence_done_o),
    .rw_valid_o(rw_valid_o), .rw_ready_i(rw_ready_i), .rw_req_o(rw_req_o),
    .rw_addr_o(rw_addr_o), .rw_size_o(rw_size_o), .data_write_o(data_write_o),
    .w_mask_o(w_mask_o), .rw_id_o(rw_id_o), .data_read_i(data_read_i),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] mask);
    wr_req_i  = 1'b1;
    wr_addr_i = addr;
    wr_data_i = data;
    wr_mask_i = mask;
    wr_size_i = 2'd3;
  endtask

  task automatic drive_read(input logic [63:0] addr);
    rd_req_i  = 1'b1;
    rd_addr_i = addr;
    rd_size_i = 2'd3;
  endtask

  // scoreboard: observed write transactions against the acceptance order
  task automatic sb_write_seen();
    if (exp_q.size() == 0) begin
      check("wr_unexpected", rw_addr_o, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      check("wr_order_addr", rw_addr_o, exp_q.pop_front());
      check("wr_order_data", data_write_o, exp_data_q.pop_front());
    end
  endtask

  initial begin
    int pulses;
    // reset state
    tick(); tick();
    check("rst_valid", rw_valid_o, 0);
    check("rst_rd_gnt", rd_gnt_o, 0);
    check("rst_rd_done", rd_done_o, 0);
    check("rst_fence_done", fence_done_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    check("rst_rw_addr", rw_addr_o, 0);
    check("rst_rw_id", rw_id_o, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;
    #1;
    check("rst_wr_gnt", wr_gnt_o, 1);

    // single read, ready after 3 cycles
    tick();
    drive_read(64'h8000_0010);
    #1;
    check("rd1_gnt", rd_gnt_o, 1);
    tick();
    rd_req_i = 1'b0;
    check("rd1_req", rw_req_o, 0);
    check("rd1_addr", rw_addr_o, 64'h8000_0010);
    check("rd1_id", rw_id_o, 0);
    for (int i = 0; i < 3; i++) begin
      check("rd1_valid", rw_valid_o, 1);
      check("rd1_gnt_low", rd_gnt_o, 0);
      if (i == 2) begin
        rw_ready_i  = 1'b1;
        data_read_i = 64'hDEAD_BEEF_1234_5678;
      end
      tick();
    end
    rw_ready_i = 1'b0;
    check("rd1_done", rd_done_o, 1);
    check("rd1_data", rd_data_o, 64'hDEAD_BEEF_1234_5678);
    check("rd1_valid_off", rw_valid_o, 0);
    tick();
    check("rd1_done_pulse", rd_done_o, 0);
    check("rd1_data_hold", rd_data_o, 64'hDEAD_BEEF_1234_5678);

    // five back-to-back writes, rw stalled
    for (int i = 0; i < 5; i++) begin
      drive_write(64'h8000_1000 + 64'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF);
      exp_q.push_back(64'h8000_1000 + 64'(i * 8));
      exp_data_q.push_back(64'hA5A5_0000_0000_0000 | 64'(i));
      #1;
      check("fill_wr_gnt", wr_gnt_o, 1);
      tick();
    end
    drive_write(64'h8000_1028, 64'h0, 8'hFF);
    #1;
    check("full_wr_gnt", wr_gnt_o, 0);
    check("full_wr_valid", rw_valid_o, 1);
    wr_req_i = 1'b0;
    tick();
    check("full_wr_gnt_hold", wr_gnt_o, 0);
    rw_ready_i = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (rw_valid_o && rw_req_o) sb_write_seen();
      tick();
    end
    rw_ready_i = 1'b0;
    check("fill_drained", exp_q.size(), 0);
    check("fill_wr_gnt_after", wr_gnt_o, 1);
    tick();

    // RAW hazard: buffered write goes before a read to the same doubleword
    drive_write(64'h8000_0008, 64'h1111_2222_3333_4444, 8'h0F);
    tick();
    wr_req_i = 1'b0;
    drive_read(64'h8000_000C);
    #1;
    check("raw_no_gnt", rd_gnt_o, 0);
    tick();
    check("raw_wr_valid", rw_valid_o, 1);
    check("raw_wr_req", rw_req_o, 1);
    check("raw_wr_addr", rw_addr_o, 64'h8000_0008);
    check("raw_wr_mask", w_mask_o, 8'h0F);
    check("raw_wr_id", rw_id_o, 1);
    tick();
    check("raw_no_gnt_wr", rd_gnt_o, 0);
    rw_ready_i = 1'b1;
    tick();
    rw_ready_i = 1'b0;
    #1;
    check("raw_gnt_after", rd_gnt_o, 1);
    tick();
    rd_req_i = 1'b0;
    check("raw_rd_req", rw_req_o, 0);
    check("raw_rd_addr", rw_addr_o, 64'h8000_000C);
    rw_ready_i  = 1'b1;
    data_read_i = 64'h0123_4567_89AB_CDEF;
    tick();
    rw_ready_i = 1'b0;
    check("raw_rd_done", rd_done_o, 1);
    check("raw_rd_data", rd_data_o, 64'h0123_4567_89AB_CDEF);

    // non-hazard read overtakes a pending write
    drive_write(64'h8000_0200, 64'h7777_8888_9999_AAAA, 8'hF0);
    tick();
    wr_req_i = 1'b0;
    drive_read(64'h8000_0100);
    #1;
    check("bypass_rd_gnt", rd_gnt_o, 1);
    tick();
    rd_req_i = 1'b0;
    check("bypass_rd_req", rw_req_o, 0);
    check("bypass_rd_addr", rw_addr_o, 64'h8000_0100);
    rw_ready_i  = 1'b1;
    data_read_i = 64'h5555_AAAA_5555_AAAA;
    tick();
    check("bypass_rd_done", rd_done_o, 1);
    check("bypass_rd_data", rd_data_o, 64'h5555_AAAA_5555_AAAA);
    tick();
    check("bypass_wr_valid", rw_valid_o, 1);
    check("bypass_wr_req", rw_req_o, 1);
    check("bypass_wr_addr", rw_addr_o, 64'h8000_0200);
    check("bypass_wr_data", data_write_o, 64'h7777_8888_9999_AAAA);
    tick();
    rw_ready_i = 1'b0;
    check("bypass_idle", rw_valid_o, 0);

    // fence drains three writes then pulses once
    for (int i = 0; i < 3; i++) begin
      drive_write(64'h8000_3000 + 64'(i * 8), 64'hFEED_0000_0000_0000 | 64'(i), 8'hFF);
      exp_q.push_back(64'h8000_3000 + 64'(i * 8));
      exp_data_q.push_back(64'hFEED_0000_0000_0000 | 64'(i));
      tick();
    end
    wr_req_i   = 1'b0;
    fence_i    = 1'b1;
    rw_ready_i = 1'b1;
    pulses     = 0;
    for (int c = 0; c < 30; c++) begin
      if (rw_valid_o && rw_req_o) sb_write_seen();
      if (fence_done_o) begin
        pulses++;
        check("fence_after_drain", exp_q.size(), 0);
      end
      tick();
    end
    check("fence_pulses", pulses, 1);
    check("fence_drained", exp_q.size(), 0);
    fence_i = 1'b0;
    tick();
    fence_i = 1'b1;
    tick();
    check("fence_rearm", fence_done_o, 1);
    tick();
    check("fence_rearm_pulse", fence_done_o, 0);
    fence_i    = 1'b0;
    rw_ready_i = 1'b0;
    tick();

    // reset in the middle of a write with two entries buffered
    for (int i = 0; i < 3; i++) begin
      drive_write(64'h8000_4000 + 64'(i * 8), 64'(i), 8'hFF);
      tick();
    end
    wr_req_i = 1'b0;
    check("midrst_pre_valid", rw_valid_o, 1);
    check("midrst_pre_full", wr_gnt_o, 1);
    reset = 1'b1;
    #1;
    check("midrst_valid", rw_valid_o, 0);
    check("midrst_state", fsm_state, 0);
    tick();
    reset      = 1'b0;
    rw_ready_i = 1'b1;
    #1;
    check("midrst_wr_gnt", wr_gnt_o, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("midrst_no_valid", rw_valid_o, 0);
      check("midrst_no_done", rd_done_o, 0);
    end
    rw_ready_i = 1'b0;

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
